// File: rtl/elevator_pkg.sv
// Shared types for the N-floor elevator controller.
//   state_e      : controller FSM states
//   dir_e        : remembered travel direction for SCAN reversal
//   req_flags_t  : request flags presented by the pending register to the FSM
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN,
    ST_DOOR,
    ST_FAULT
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef struct packed {
    logic here;   // pending request at the registered floor
    logic above;  // any pending request above the registered floor
    logic below;  // any pending request below the registered floor
    logic press;  // a call for the registered floor is being made this cycle
  } req_flags_t;

endpackage

// File: rtl/elevator_ctrl_n_if.sv
// Button/sensor inputs and motor/door outputs of the elevator controller.
//   master : drives current_floor and button calls, observes commands
//   slave  : the controller
interface elevator_ctrl_n_if #(
  parameter int unsigned NUM_FLOORS = 8
);
  localparam int unsigned FLOOR_W = $clog2(NUM_FLOORS);

  logic [FLOOR_W-1:0]    current_floor;
  logic [NUM_FLOORS-1:0] buttons_in;
  logic [NUM_FLOORS-1:0] buttons_out;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  dir_down;
  logic                  door_open;
  logic                  fault;

  modport master (
    output current_floor, buttons_in, buttons_out,
    input  pending, dir_up, dir_down, door_open, fault
  );

  modport slave (
    input  current_floor, buttons_in, buttons_out,
    output pending, dir_up, dir_down, door_open, fault
  );

endinterface

// File: rtl/elevator_req_reg.sv
// Pending-request register with here/above/below flag generation.
//   floor_in  : raw floor sensor, registered here so flags use a stable floor
//   req       : combined cabin and hall calls
//   clr_here  : drop the request at the registered floor (door phase)
//   pending   : latched outstanding requests (registered)
//   flags_c   : combinational flags derived from pending and the registered floor
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter  int unsigned NUM_FLOORS = 8,
  localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    floor_in,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  clr_here,
  output logic [NUM_FLOORS-1:0] pending,
  output req_flags_t            flags_c
);

  logic [FLOOR_W-1:0]    floor_q;
  logic [NUM_FLOORS-1:0] pending_next;

  // Set from any call; the clear at the door floor wins over a simultaneous press.
  always_comb begin
    pending_next = pending | req;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (clr_here && (FLOOR_W'(i) == floor_q)) pending_next[i] = 1'b0;
    end
  end

  // Position of every pending bit relative to the registered floor.
  always_comb begin
    flags_c = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == floor_q) begin
        flags_c.here  = flags_c.here  | pending[i];
        flags_c.press = flags_c.press | req[i];
      end
      if (FLOOR_W'(i) > floor_q) flags_c.above = flags_c.above | pending[i];
      if (FLOOR_W'(i) < floor_q) flags_c.below = flags_c.below | pending[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      floor_q <= '0;
    end else begin
      pending <= pending_next;
      floor_q <= floor_in;
    end
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller: FSM, door timer and registered commands.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : sensor/button inputs, pending/motor/door/fault outputs
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned DOOR_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  elevator_ctrl_n_if.slave bus
);

  localparam int unsigned TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

  state_e               state, state_next;
  dir_e                 last_dir, last_dir_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  req_flags_t           flags_c;
  logic                 fault_in_c;
  logic                 clr_here_c;
  logic                 dir_up_q, dir_down_q, door_open_q, fault_q;

  elevator_req_reg #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_req (
    .clk      (clk),
    .reset    (reset),
    .floor_in (bus.current_floor),
    .req      (bus.buttons_in | bus.buttons_out),
    .clr_here (clr_here_c),
    .pending  (bus.pending),
    .flags_c  (flags_c)
  );

  assign fault_in_c = (32'(bus.current_floor) >= NUM_FLOORS);
  // The door floor's request is dropped on the entry edge and for the whole door phase.
  assign clr_here_c = (state == ST_DOOR) || (state_next == ST_DOOR);

  // Next state, door timer and travel memory.
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    last_dir_next = last_dir;
    if (fault_in_c) begin
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flags_c.here) begin
            state_next = ST_DOOR;
            timer_next = DOOR_LOAD;
          end else if (flags_c.above) begin
            state_next = ST_UP;
          end else if (flags_c.below) begin
            state_next = ST_DOWN;
          end
        end
        ST_UP: begin
          if (flags_c.here) begin
            state_next    = ST_DOOR;
            timer_next    = DOOR_LOAD;
            last_dir_next = DIR_UP;
          end
        end
        ST_DOWN: begin
          if (flags_c.here) begin
            state_next    = ST_DOOR;
            timer_next    = DOOR_LOAD;
            last_dir_next = DIR_DOWN;
          end
        end
        ST_DOOR: begin
          if (flags_c.press) begin
            timer_next = DOOR_LOAD;
          end else if (timer == '0) begin
            // SCAN: keep heading while work remains ahead, else reverse.
            if (last_dir == DIR_UP) begin
              state_next = flags_c.above ? ST_UP : (flags_c.below ? ST_DOWN : ST_IDLE);
            end else begin
              state_next = flags_c.below ? ST_DOWN : (flags_c.above ? ST_UP : ST_IDLE);
            end
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // State, timer and Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      last_dir    <= DIR_UP;
      dir_up_q    <= 1'b0;
      dir_down_q  <= 1'b0;
      door_open_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      last_dir    <= last_dir_next;
      dir_up_q    <= (state_next == ST_UP);
      dir_down_q  <= (state_next == ST_DOWN);
      door_open_q <= (state_next == ST_DOOR);
      fault_q     <= (state_next == ST_FAULT);
    end
  end

  assign bus.dir_up    = dir_up_q;
  assign bus.dir_down  = dir_down_q;
  assign bus.door_open = door_open_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n: an 8-floor instance checked every
// cycle against a behavioural model, plus a 6-floor instance for the fault path.
module tb_elevator_ctrl_n;

  localparam int NF = 8;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_ctrl_n_if #(.NUM_FLOORS(8)) bus8 ();
  elevator_ctrl_n_if #(.NUM_FLOORS(6)) bus6 ();

  elevator_ctrl_n #(.NUM_FLOORS(8), .DOOR_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus8)
  );
  elevator_ctrl_n #(.NUM_FLOORS(6), .DOOR_CYCLES(4)) dut6 (
    .clk(clk), .reset(reset), .bus(bus6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: request set, cab motion (+1/-1/0), door cycles left, heading.
  logic [7:0] m_pend;
  int m_floor, m_motion, m_door, m_heading;

  // Environment: floor position moved by the cab's commands, event log.
  int cf, mv_cnt, door_cnt;
  int ev[$];
  logic p_up, p_down, p_door;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_floor = 0; m_motion = 0; m_door = 0; m_heading = 1;
    p_up = 1'b0; p_down = 1'b0; p_door = 1'b0; mv_cnt = 0;
  endtask

  task automatic model_step();
    logic [7:0] b;
    logic here, above, below, clr;
    b     = bus8.buttons_in | bus8.buttons_out;
    here  = m_pend[m_floor];
    above = (m_pend >> (m_floor + 1)) != 8'd0;
    below = (m_pend & 8'((1 << m_floor) - 1)) != 8'd0;
    clr   = 1'b0;
    if (m_door > 0) begin
      clr = 1'b1;
      if (b[m_floor]) m_door = DC;
      else if (m_door == 1) begin
        m_door = 0;
        if (m_heading > 0) m_motion = above ? 1 : (below ? -1 : 0);
        else               m_motion = below ? -1 : (above ? 1 : 0);
      end else m_door--;
    end else if (m_motion == 0) begin
      if (here) begin m_door = DC; clr = 1'b1; end
      else if (above) m_motion = 1;
      else if (below) m_motion = -1;
    end else if (here) begin
      m_heading = m_motion; m_motion = 0; m_door = DC; clr = 1'b1;
    end
    m_pend = m_pend | b;
    if (clr) m_pend[m_floor] = 1'b0;
    m_floor = int'(bus8.current_floor);
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".pending"},   32'(bus8.pending),   32'(m_pend));
    cmp({tag, ".dir_up"},    32'(bus8.dir_up),    32'(m_motion == 1 && m_door == 0));
    cmp({tag, ".dir_down"},  32'(bus8.dir_down),  32'(m_motion == -1 && m_door == 0));
    cmp({tag, ".door_open"}, 32'(bus8.door_open), 32'(m_door > 0));
    cmp({tag, ".fault"},     32'(bus8.fault),     32'(0));
  endtask

  // One clock: model and DUT advance, compare, log events, move the cab.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    if (bus8.dir_up && !p_up)       ev.push_back(1);
    if (bus8.dir_down && !p_down)   ev.push_back(-1);
    if (bus8.door_open && !p_door)  ev.push_back(100 + cf);
    if (bus8.door_open) door_cnt++;
    p_up = bus8.dir_up; p_down = bus8.dir_down; p_door = bus8.door_open;
    if (bus8.dir_up || bus8.dir_down) begin
      mv_cnt++;
      if (mv_cnt == 3) begin
        mv_cnt = 0;
        if (bus8.dir_up && cf < NF - 1) cf++;
        else if (bus8.dir_down && cf > 0) cf--;
      end
    end else mv_cnt = 0;
    bus8.current_floor = 3'(cf);
  endtask

  task automatic run_idle(input string tag, input int max);
    int k = 0;
    while (!(m_pend == 8'd0 && m_motion == 0 && m_door == 0) && k < max) begin
      tick(tag);
      k++;
    end
    cmp({tag, ".settled"}, 32'(k < max), 32'(1));
  endtask

  task automatic check_ev(input string tag, input int n, input int a, input int b,
                          input int c, input int d);
    int e[4];
    e = '{a, b, c, d};
    cmp({tag, ".ev_count"}, 32'(ev.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < ev.size()) cmp({tag, ".ev"}, 32'(ev[i]), 32'(e[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cf = 0; door_cnt = 0;
    bus8.current_floor = '0; bus8.buttons_in = '0; bus8.buttons_out = '0;
    bus6.current_floor = '0; bus6.buttons_in = '0; bus6.buttons_out = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    cmp("reset.fault6", 32'(bus6.fault), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // Hall call to floor 5 from the ground: 1-cycle latch, 2-cycle motion.
    bus8.buttons_out[5] = 1'b1;
    tick("s1.latch");
    bus8.buttons_out[5] = 1'b0;
    cmp("s1.pending", 32'(bus8.pending), 32'h20);
    cmp("s1.no_move_yet", 32'(bus8.dir_up), 32'(0));
    tick("s1.move");
    cmp("s1.dir_up", 32'(bus8.dir_up), 32'(1));
    run_idle("s1", 200);
    check_ev("s1", 2, 1, 105, 0, 0);
    cmp("s1.door_cycles", 32'(door_cnt), 32'(DC));
    cmp("s1.pending_clear", 32'(bus8.pending), 32'h0);

    // Park at floor 3, then requests at 7 and 1: up first, reverse after 7.
    bus8.buttons_in[3] = 1'b1;
    tick("s2.park");
    bus8.buttons_in[3] = 1'b0;
    run_idle("s2.park", 200);
    ev.delete();
    bus8.buttons_in[7] = 1'b1; bus8.buttons_out[1] = 1'b1;
    tick("s2.press");
    bus8.buttons_in[7] = 1'b0; bus8.buttons_out[1] = 1'b0;
    run_idle("s2", 300);
    check_ev("s2", 4, 1, 107, -1, 101);

    // Park at floor 4, then 2 and 6 together: tie goes up.
    bus8.buttons_in[4] = 1'b1;
    tick("s3.park");
    bus8.buttons_in[4] = 1'b0;
    run_idle("s3.park", 200);
    ev.delete();
    bus8.buttons_out[2] = 1'b1; bus8.buttons_in[6] = 1'b1;
    tick("s3.press");
    bus8.buttons_out[2] = 1'b0; bus8.buttons_in[6] = 1'b0;
    run_idle("s3", 300);
    check_ev("s3", 4, 1, 106, -1, 102);

    // Door at floor 4 extended by a press on its third cycle.
    ev.delete();
    door_cnt = 0;
    bus8.buttons_in[4] = 1'b1;
    tick("s4.press");
    bus8.buttons_in[4] = 1'b0;
    begin
      bit pressed, pressed_now, done;
      int dcnt;
      pressed = 1'b0; pressed_now = 1'b0; done = 1'b0; dcnt = 0;
      for (int k = 0; k < 100 && !done; k++) begin
        tick("s4");
        bus8.buttons_in[4] = 1'b0;
        if (pressed_now) begin
          cmp("s4.pend4_blocked", 32'(bus8.pending[4]), 32'(0));
          pressed_now = 1'b0;
        end
        if (bus8.door_open) dcnt++;
        else if (dcnt > 0) done = 1'b1;
        if (dcnt == 3 && bus8.door_open && !pressed) begin
          bus8.buttons_in[4] = 1'b1;
          pressed = 1'b1;
          pressed_now = 1'b1;
        end
      end
      cmp("s4.door_closed", 32'(done), 32'(1));
      cmp("s4.door_cycles", 32'(dcnt), 32'(7));
    end
    run_idle("s4", 50);
    check_ev("s4", 2, 1, 104, 0, 0);

    // Asynchronous reset while moving up.
    bus8.buttons_in[7] = 1'b1;
    tick("s5.press");
    bus8.buttons_in[7] = 1'b0;
    begin
      int k;
      k = 0;
      while (!bus8.dir_up && k < 6) begin tick("s5.wait"); k++; end
    end
    cmp("s5.moving", 32'(bus8.dir_up), 32'(1));
    #2 reset = 1'b1;
    #1;
    model_reset();
    cmp("s5.async_dir_up",  32'(bus8.dir_up),    32'(0));
    cmp("s5.async_dir_dn",  32'(bus8.dir_down),  32'(0));
    cmp("s5.async_door",    32'(bus8.door_open), 32'(0));
    cmp("s5.async_pending", 32'(bus8.pending),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      tick("s5.after");
      cmp("s5.no_motion", 32'(bus8.dir_up | bus8.dir_down), 32'(0));
    end

    // Random calls against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) bus8.buttons_in[$urandom_range(0, NF - 1)] = 1'b1;
        else                           bus8.buttons_out[$urandom_range(0, NF - 1)] = 1'b1;
      end
      tick("rnd");
      bus8.buttons_in = '0;
      bus8.buttons_out = '0;
    end
    run_idle("rnd.drain", 400);

    // Out-of-range floor on the 6-floor instance: sticky fault.
    @(negedge clk);
    bus6.current_floor = 3'd7;
    @(posedge clk);
    #1;
    cmp("f.fault",    32'(bus6.fault),     32'(1));
    cmp("f.dir_up",   32'(bus6.dir_up),    32'(0));
    cmp("f.dir_down", 32'(bus6.dir_down),  32'(0));
    cmp("f.door",     32'(bus6.door_open), 32'(0));
    bus6.current_floor = 3'd2;
    bus6.buttons_in[3] = 1'b1;
    @(posedge clk);
    #1;
    bus6.buttons_in = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("f.sticky",   32'(bus6.fault),   32'(1));
    cmp("f.latching", 32'(bus6.pending), 32'h08);
    cmp("f.no_move",  32'(bus6.dir_up | bus6.dir_down | bus6.door_open), 32'(0));
    reset = 1'b1;
    #1;
    cmp("f.reset_fault",   32'(bus6.fault),   32'(0));
    cmp("f.reset_pending", 32'(bus6.pending), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
